zone_max_pool: RTL

Streaming local-dimming statistics stage. It takes the per-pixel gray stream produced by `rgb_to_gray` and reduces each frame to 360 zone maxima on the fly, over a 24 × 15 grid of 80 × 72-pixel zones. It writes those maxima directly into the `buffer_360` write port (`buf_en` / `cnt_buf` / `gray`). This gives a DDR-free path that bypasses `addr_wr`, `ddr3_syn_top` and `ddr_rd_receiver`.

---
 rtl/zone_max_pool.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/zone_max_pool.sv
// Streaming zone-maximum stage: folds each frame's gray stream into ZONES_X x ZONES_Y
// zone maxima and writes them band by band into the zone buffer write port.
module zone_max_pool #(
    parameter int H_ACT   = 1920,
    parameter int V_ACT   = 1080,
    parameter int ZONES_X = 24,
    parameter int ZONES_Y = 15,
    parameter int ZONE_W  = 80,
    parameter int ZONE_H  = 72
) (
    input  logic        i_pix_clk,
    input  logic        rst_n,
    input  logic        data_de,
    input  logic [7:0]  gray,
    input  logic [10:0] pix_x,
    input  logic [10:0] pix_y,
    output logic        buf_en,
    output logic [8:0]  cnt_buf,
    output logic [7:0]  max_gray,
    output logic        frame_done,
    output logic        overrun
);

    localparam int XCW = $clog2(ZONE_W);
    localparam int ZXW = $clog2(ZONES_X);
    localparam int YCW = $clog2(ZONE_H);
    localparam int ZYW = $clog2(ZONES_Y);

    typedef enum logic [1:0] {WAIT_SOF, ACCUM, FLUSH} state_t;

    state_t           stateQ, stateD;
    logic [XCW-1:0]   xCntQ, xCntD;
    logic [ZXW-1:0]   zxQ, zxD;
    logic [YCW-1:0]   yInQ, yInD;
    logic [ZYW-1:0]   zyQ, zyD;
    logic [ZXW-1:0]   idxQ, idxD;
    logic [7:0]       accQ [ZONES_X];
    logic [7:0]       accD [ZONES_X];

    logic             s1ValidQ, s1SofQ, s1LastColQ;
    logic [7:0]       s1GrayQ;
    logic [ZXW-1:0]   s1ZxQ;
    logic [YCW-1:0]   s1YinQ;

    logic             bufEnQ, bufEnD;
    logic [8:0]       cntBufQ, cntBufD;
    logic [7:0]       maxGrayQ, maxGrayD;
    logic             frameDoneQ, frameDoneD;
    logic             overrunQ, overrunD;

    logic             inRange, lineStart, bandEnd;

    assign inRange   = data_de && (pix_x < 11'(H_ACT)) && (pix_y < 11'(V_ACT));
    assign lineStart = (pix_x == 11'd0);
    assign bandEnd   = s1ValidQ && s1LastColQ && (s1YinQ == YCW'(ZONE_H - 1));

    // Zone column / row-in-band counters; their next values label the incoming sample.
    always_comb begin
        xCntD = xCntQ;
        zxD   = zxQ;
        yInD  = yInQ;
        if (inRange) begin
            if (lineStart) begin
                xCntD = '0;
                zxD   = '0;
                if (pix_y == 11'd0 || yInQ == YCW'(ZONE_H - 1)) begin
                    yInD = '0;
                end else begin
                    yInD = yInQ + YCW'(1);
                end
            end else if (xCntQ == XCW'(ZONE_W - 1)) begin
                xCntD = '0;
                zxD   = zxQ + ZXW'(1);
            end else begin
                xCntD = xCntQ + XCW'(1);
            end
        end
    end

    always_comb begin
        stateD     = stateQ;
        accD       = accQ;
        zyD        = zyQ;
        idxD       = idxQ;
        bufEnD     = 1'b0;
        cntBufD    = cntBufQ;
        maxGrayD   = maxGrayQ;
        frameDoneD = 1'b0;
        overrunD   = overrunQ;
        if (s1SofQ) begin
            for (int i = 0; i < ZONES_X; i++) begin
                accD[i] = '0;
            end
            accD[s1ZxQ] = s1GrayQ;
            zyD         = '0;
            idxD        = '0;
            overrunD    = 1'b0;
            stateD      = ACCUM;
        end else begin
            if (s1ValidQ && stateQ != WAIT_SOF && s1GrayQ > accQ[s1ZxQ]) begin
                accD[s1ZxQ] = s1GrayQ;
            end
            case (stateQ)
                WAIT_SOF: stateD = WAIT_SOF;
                ACCUM: begin
                    if (bandEnd) begin
                        stateD = FLUSH;
                        idxD   = '0;
                    end
                end
                FLUSH: begin
                    // A sample merged into an already emitted column survives into the next band.
                    if (s1ValidQ) begin
                        overrunD = 1'b1;
                    end
                    bufEnD      = 1'b1;
                    cntBufD     = 9'(int'(zyQ) * ZONES_X + int'(idxQ));
                    maxGrayD    = accQ[idxQ];
                    accD[idxQ]  = '0;
                    if (idxQ == ZXW'(ZONES_X - 1)) begin
                        idxD = '0;
                        if (zyQ == ZYW'(ZONES_Y - 1)) begin
                            frameDoneD = 1'b1;
                            zyD        = '0;
                            stateD     = WAIT_SOF;
                        end else begin
                            zyD    = zyQ + ZYW'(1);
                            stateD = ACCUM;
                        end
                    end else begin
                        idxD = idxQ + ZXW'(1);
                    end
                end
                default: stateD = WAIT_SOF;
            endcase
        end
    end

    always_ff @(posedge i_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ     <= WAIT_SOF;
            xCntQ      <= '0;
            zxQ        <= '0;
            yInQ       <= '0;
            zyQ        <= '0;
            idxQ       <= '0;
            for (int i = 0; i < ZONES_X; i++) begin
                accQ[i] <= '0;
            end
            s1ValidQ   <= 1'b0;
            s1SofQ     <= 1'b0;
            s1LastColQ <= 1'b0;
            s1GrayQ    <= '0;
            s1ZxQ      <= '0;
            s1YinQ     <= '0;
            bufEnQ     <= 1'b0;
            cntBufQ    <= '0;
            maxGrayQ   <= '0;
            frameDoneQ <= 1'b0;
            overrunQ   <= 1'b0;
        end else begin
            stateQ     <= stateD;
            xCntQ      <= xCntD;
            zxQ        <= zxD;
            yInQ       <= yInD;
            zyQ        <= zyD;
            idxQ       <= idxD;
            accQ       <= accD;
            s1ValidQ   <= inRange;
            s1SofQ     <= inRange && lineStart && (pix_y == 11'd0);
            s1LastColQ <= (pix_x == 11'(H_ACT - 1));
            s1GrayQ    <= gray;
            s1ZxQ      <= zxD;
            s1YinQ     <= yInD;
            bufEnQ     <= bufEnD;
            cntBufQ    <= cntBufD;
            maxGrayQ   <= maxGrayD;
            frameDoneQ <= frameDoneD;
            overrunQ   <= overrunD;
        end
    end

    assign buf_en     = bufEnQ;
    assign cnt_buf    = cntBufQ;
    assign max_gray   = maxGrayQ;
    assign frame_done = frameDoneQ;
    assign overrun    = overrunQ;

endmodule
